// File: rtl/exu_oitf_if.sv
// Dispatch / retire / hazard-check bundle for the outstanding-instruction tracking FIFO.
// The master side (dispatch and writeback logic) drives the requests.
// The slave side (the OITF) returns status, the head payload and the hazard flags.
interface exu_oitf_if #(
    parameter int unsigned PTR_W       = 2,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned PC_SIZE     = 32
);
    // Allocation request and status
    logic                   dis_ena;
    logic                   dis_ready;
    logic [PTR_W-1:0]       dis_ptr;

    // Payload stored at allocation
    logic                   disp_i_rdwen;
    logic [RFIDX_WIDTH-1:0] disp_i_rdidx;
    logic [PC_SIZE-1:0]     disp_i_pc;

    // Hazard-check request
    logic                   disp_i_rs1en;
    logic                   disp_i_rs2en;
    logic                   disp_i_rdwen_chk;
    logic [RFIDX_WIDTH-1:0] disp_i_rs1idx;
    logic [RFIDX_WIDTH-1:0] disp_i_rs2idx;
    logic [RFIDX_WIDTH-1:0] disp_i_rdidx_chk;

    // Hazard flags
    logic                   oitfrd_match_disprs1;
    logic                   oitfrd_match_disprs2;
    logic                   oitfrd_match_disprd;

    // Retirement and head entry
    logic                   ret_ena;
    logic [PTR_W-1:0]       ret_ptr;
    logic                   ret_rdwen;
    logic [RFIDX_WIDTH-1:0] ret_rdidx;
    logic [PC_SIZE-1:0]     ret_pc;
    logic                   oitf_empty;

    modport master (
        output dis_ena, disp_i_rdwen, disp_i_rdidx, disp_i_pc,
        output disp_i_rs1en, disp_i_rs2en, disp_i_rdwen_chk,
        output disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx_chk,
        output ret_ena,
        input  dis_ready, dis_ptr,
        input  oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd,
        input  ret_ptr, ret_rdwen, ret_rdidx, ret_pc, oitf_empty
    );

    modport slave (
        input  dis_ena, disp_i_rdwen, disp_i_rdidx, disp_i_pc,
        input  disp_i_rs1en, disp_i_rs2en, disp_i_rdwen_chk,
        input  disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx_chk,
        input  ret_ena,
        output dis_ready, dis_ptr,
        output oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd,
        output ret_ptr, ret_rdwen, ret_rdidx, ret_pc, oitf_empty
    );
endinterface

// File: rtl/exu_oitf.sv
// Outstanding Instruction Track FIFO.
// It records the destination register of every long-pipe instruction still in flight.
// Entries are retired in order at writeback.
// Incoming source and destination indexes are matched against all live entries for hazards.
module exu_oitf #(
    parameter int unsigned OITF_DEPTH  = 4,
    parameter int unsigned PTR_W       = 2,
    parameter int unsigned RFIDX_WIDTH = 5,
    parameter int unsigned PC_SIZE     = 32
) (
    input logic       clk,
    input logic       rst_n,
    exu_oitf_if.slave oitf
);
    localparam logic [PTR_W-1:0] LastPtr = PTR_W'(OITF_DEPTH - 1);

    // Pointers with wrap flags: equal pointers mean empty or full, and the flags tell which
    logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic             alloc_flg_q, alloc_flg_d;
    logic [PTR_W-1:0] ret_ptr_q, ret_ptr_d;
    logic             ret_flg_q, ret_flg_d;

    logic [OITF_DEPTH-1:0] valid_q, valid_d;

    // Payload storage is not reset; every read of it is qualified by a valid bit or by !empty
    logic                   rdwen_q [OITF_DEPTH];
    logic [RFIDX_WIDTH-1:0] rdidx_q [OITF_DEPTH];
    logic [PC_SIZE-1:0]     pc_q    [OITF_DEPTH];

    logic ptr_eq;
    logic full;
    logic empty;
    logic alloc_fire;
    logic ret_fire;

    // Occupancy status and the qualified allocate/retire strobes
    always_comb begin
        ptr_eq     = (alloc_ptr_q == ret_ptr_q);
        empty      = ptr_eq & (alloc_flg_q == ret_flg_q);
        full       = ptr_eq & (alloc_flg_q != ret_flg_q);
        // Requests that cannot be honoured (allocate when full, retire when empty) are dropped
        alloc_fire = oitf.dis_ena & ~full;
        ret_fire   = oitf.ret_ena & ~empty;
    end

    // Next-state for both pointers and the valid vector
    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        alloc_flg_d = alloc_flg_q;
        ret_ptr_d   = ret_ptr_q;
        ret_flg_d   = ret_flg_q;
        valid_d     = valid_q;

        if (alloc_fire) begin
            valid_d[alloc_ptr_q] = 1'b1;
            if (alloc_ptr_q == LastPtr) begin
                alloc_ptr_d = '0;
                alloc_flg_d = ~alloc_flg_q;
            end else begin
                alloc_ptr_d = alloc_ptr_q + PTR_W'(1);
            end
        end

        // Retire and allocate never target the same slot: that needs full or empty,
        // and either condition blocks one of the two strobes.
        if (ret_fire) begin
            valid_d[ret_ptr_q] = 1'b0;
            if (ret_ptr_q == LastPtr) begin
                ret_ptr_d = '0;
                ret_flg_d = ~ret_flg_q;
            end else begin
                ret_ptr_d = ret_ptr_q + PTR_W'(1);
            end
        end
    end

    // Control state; asynchronous reset drops every entry at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr_q <= '0;
            alloc_flg_q <= 1'b0;
            ret_ptr_q   <= '0;
            ret_flg_q   <= 1'b0;
            valid_q     <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            alloc_flg_q <= alloc_flg_d;
            ret_ptr_q   <= ret_ptr_d;
            ret_flg_q   <= ret_flg_d;
            valid_q     <= valid_d;
        end
    end

    // Payload capture into the slot being allocated
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rdwen_q[alloc_ptr_q] <= oitf.disp_i_rdwen;
            rdidx_q[alloc_ptr_q] <= oitf.disp_i_rdidx;
            pc_q[alloc_ptr_q]    <= oitf.disp_i_pc;
        end
    end

    logic hit_rs1;
    logic hit_rs2;
    logic hit_rd;

    // Hazard search over registered valid entries; no exemption for x0
    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        hit_rd  = 1'b0;
        for (int unsigned i = 0; i < OITF_DEPTH; i++) begin
            if (valid_q[i] && rdwen_q[i]) begin
                if (rdidx_q[i] == oitf.disp_i_rs1idx) hit_rs1 = 1'b1;
                if (rdidx_q[i] == oitf.disp_i_rs2idx) hit_rs2 = 1'b1;
                if (rdidx_q[i] == oitf.disp_i_rdidx_chk) hit_rd = 1'b1;
            end
        end
    end

    // Status, head payload and hazard flags
    always_comb begin
        oitf.dis_ready            = ~full;
        oitf.dis_ptr              = alloc_ptr_q;
        oitf.ret_ptr              = ret_ptr_q;
        oitf.oitf_empty           = empty;
        oitf.ret_rdwen            = empty ? 1'b0 : rdwen_q[ret_ptr_q];
        oitf.ret_rdidx            = empty ? '0 : rdidx_q[ret_ptr_q];
        oitf.ret_pc               = empty ? '0 : pc_q[ret_ptr_q];
        oitf.oitfrd_match_disprs1 = oitf.disp_i_rs1en & hit_rs1;
        oitf.oitfrd_match_disprs2 = oitf.disp_i_rs2en & hit_rs2;
        oitf.oitfrd_match_disprd  = oitf.disp_i_rdwen_chk & hit_rd;
    end

endmodule

// File: doc/exu_oitf.md
EXU_OITF -- requirements
Module: exu_oitf

Interface
REQ-001 Parameter: OITF_DEPTH, default 4, number of outstanding long-pipe entries; shall be a power of two, at least 2.
REQ-002 Parameter: PTR_W, default 2, equal to log2(OITF_DEPTH).
REQ-003 Parameter: RFIDX_WIDTH, default 5, register index width.
REQ-004 Parameter: PC_SIZE, default 32, PC width.
REQ-005 Clock and reset shall be as follows: one clock; reset is asynchronous and active-low (ports clk and rst_n).
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 dis_ena  in  1  allocate one entry for the instruction being dispatched.
REQ-009 dis_ready  out  1  an entry is free (not full).
REQ-010 dis_ptr  out  PTR_W  index of the entry that dis_ena allocates (the allocation pointer).
REQ-011 disp_i_rdwen, disp_i_rdidx[RFIDX_WIDTH], disp_i_pc[PC_SIZE]  in  payload stored at allocation.
REQ-012 disp_i_rs1en, disp_i_rs2en, disp_i_rdwen_chk  in  1 each  source/destination check enables.
REQ-013 disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx_chk  in  RFIDX_WIDTH  indexes to check against outstanding entries.
REQ-014 oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd  out  1 each  hazard flags.
REQ-015 ret_ena  in  1  retire the head entry (from the long-pipe writeback).
REQ-016 ret_ptr  out  PTR_W  head entry index.
REQ-017 ret_rdwen  out  1; ret_rdidx  out  RFIDX_WIDTH; ret_pc  out  PC_SIZE  head entry payload.
REQ-018 oitf_empty  out  1  no valid entries.

Function
REQ-019 Circular FIFO: alloc_ptr/alloc_flg and ret_ptr/ret_flg; each pointer increments by 1 and wraps from OITF_DEPTH-1 to 0, toggling its flag on wrap.
REQ-020 Empty when the pointers are equal and the flags are equal; full when the pointers are equal and the flags differ; dis_ready = !full.
REQ-021 Allocation occurs on the clock edge where dis_ena & dis_ready; it writes the entry at alloc_ptr, sets that entry's valid bit, and advances alloc_ptr; the stored entry becomes visible on the next cycle.
REQ-022 dis_ena while full is a protocol violation; it shall be ignored, with no state change.
REQ-023 Retirement occurs on the clock edge where ret_ena & !oitf_empty; it clears the valid bit at ret_ptr and advances ret_ptr; ret_ena while empty shall be ignored.
REQ-024 Simultaneous allocation and retirement in the same cycle shall both take effect; the occupancy count is unchanged.
REQ-025 When empty, an allocation in the same cycle is not retirable in that cycle; ret_ena is ignored.
REQ-026 ret_rdwen, ret_rdidx and ret_pc are combinational reads of the entry at ret_ptr; all are forced to 0 when oitf_empty.
REQ-027 oitfrd_match_disprs1 = OR over valid entries of (entry.rdwen & disp_i_rs1en & entry.rdidx == disp_i_rs1idx); oitfrd_match_disprs2 and oitfrd_match_disprd are formed identically with their own enable and index.
REQ-028 The match outputs are purely combinational, with zero latency and no special handling of index 0.
REQ-029 The match logic uses the registered valid bits only; an allocation in the current cycle does not affect matches in that cycle.

Reset
REQ-030 While rst_n=0: both pointers and flags are 0, all valid bits are 0, oitf_empty=1, dis_ready=1, dis_ptr=0, ret_ptr=0, ret_* payload is 0, and all match outputs are 0.
REQ-031 Reset asserted mid-operation shall discard all entries immediately, without waiting for a clock edge.
REQ-032 Entry payload registers do not require reset.

Verification
REQ-033 Reset -> oitf_empty=1, dis_ready=1, dis_ptr=0, ret_ptr=0, ret_rdwen=0.
REQ-034 Four allocations with rdidx 1,2,3,4 and no retirement -> dis_ready=0 after the fourth; a fifth dis_ena leaves state unchanged; ret_rdidx=1.
REQ-035 From full, four ret_ena cycles -> ret_rdidx sequence 1,2,3,4, then oitf_empty=1; a further ret_ena is ignored.
REQ-036 Hold one entry, then assert dis_ena and ret_ena together for 10 cycles -> occupancy stays 1; the pointers wrap with their flags toggling; no false full or empty.
REQ-037 Entry with rdwen=1, rdidx=5 outstanding; disp_i_rs1en=1, rs1idx=5 -> oitfrd_match_disprs1=1. With rs1en=0 or rs1idx=6 -> 0. After the entry retires -> 0.
REQ-038 Three entries valid, rst_n pulsed low between clock edges -> oitf_empty=1 and all valid bits clear before the next edge.
